// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit/request-to-send, shifts one command byte
// out on device clock edges, checks the device ack and enforces protocol timeouts.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int SETUP_CYCLES   = 25,
  parameter int START_TIMEOUT  = 375000,
  parameter int PACKET_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQUEST, WAIT_START, XFER, WAIT_IDLE, FAIL
  } state_t;

  // Limits are "last cycle" values so each timed state dwells exactly N cycles.
  localparam logic [18:0] INH_LAST   = 19'(INHIBIT_CYCLES - 1);
  localparam logic [18:0] SETUP_LAST = 19'(SETUP_CYCLES - 1);
  localparam logic [18:0] START_LAST = 19'(START_TIMEOUT - 1);
  localparam logic [18:0] PKT_LAST   = 19'(PACKET_TIMEOUT - 1);
  localparam logic [18:0] CNT_MAX    = '1;

  state_t      state_q, state_d;
  logic [1:0]  clk_sync_q, data_sync_q;
  logic        clk_prev_q;
  logic [18:0] cnt_q;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [8:0]  shift_q, shift_d;
  logic        txbit_q, txbit_d;
  logic        done_q, done_d;
  logic        fall;

  assign fall = clk_prev_q & ~clk_sync_q[1];
  assign done = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      txbit_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      txbit_q     <= txbit_d;
      done_q      <= done_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 19'd1;
    end
  end

  always_comb begin
    state_d            = state_q;
    bitcnt_d           = bitcnt_q;
    shift_d            = shift_q;
    txbit_d            = txbit_q;
    done_d             = 1'b0;
    ps2_clk_drive_low  = 1'b0;
    ps2_data_drive_low = 1'b0;
    busy               = 1'b1;
    error              = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (tx_start) begin
          shift_d  = {~^tx_data, tx_data};
          bitcnt_d = '0;
          txbit_d  = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_drive_low = 1'b1;
        if (cnt_q >= INH_LAST) state_d = REQUEST;
      end
      REQUEST: begin
        ps2_clk_drive_low  = 1'b1;
        ps2_data_drive_low = 1'b1;
        if (cnt_q >= SETUP_LAST) state_d = WAIT_START;
      end
      WAIT_START: begin
        ps2_data_drive_low = 1'b1;
        if (fall) begin
          bitcnt_d = 4'd1;
          txbit_d  = shift_q[0];
          shift_d  = {1'b1, shift_q[8:1]};
          state_d  = XFER;
        end else if (cnt_q >= START_LAST) begin
          state_d = FAIL;
        end
      end
      XFER: begin
        ps2_data_drive_low = ~txbit_q;
        if (fall) begin
          bitcnt_d = bitcnt_q + 4'd1;
          // Edge 11 is the device ack slot; ones shifted in behind parity form the stop bit.
          if (bitcnt_q == 4'd10) begin
            state_d = data_sync_q[1] ? FAIL : WAIT_IDLE;
          end else begin
            txbit_d = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
          end
        end else if (cnt_q >= PKT_LAST) begin
          state_d = FAIL;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync_q[1] && data_sync_q[1]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q >= PKT_LAST) begin
          state_d = FAIL;
        end
      end
      FAIL: begin
        busy    = 1'b0;
        error   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH  = 2500;
  localparam int SETP = 25;
  localparam int STO  = 4000;
  localparam int PTO  = 2000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       dev_clk, dev_data;
  logic       ps2_clk, ps2_data;
  logic       ps2_clk_drive_low, ps2_data_drive_low, busy, done, error;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int d0, e0, inh, setp, n;
  logic [10:0] frame;

  always #5 clk = ~clk;

  assign ps2_clk  = dev_clk  & ~ps2_clk_drive_low;
  assign ps2_data = dev_data & ~ps2_data_drive_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .SETUP_CYCLES(SETP),
    .START_TIMEOUT(STO), .PACKET_TIMEOUT(PTO)
  ) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
    .busy(busy), .done(done), .error(error)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) both_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accepts a byte, then measures clock-only-low time and both-low time.
  task automatic start_and_measure(input logic [7:0] b, output int inh_n, output int setp_n);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_clk_drv", ps2_clk_drive_low, 1);
    check("accept_data_drv", ps2_data_drive_low, 0);
    inh_n = 0;
    while (!ps2_data_drive_low && inh_n < 10000) begin
      @(negedge clk);
      inh_n++;
    end
    setp_n = 0;
    while (ps2_clk_drive_low && setp_n < 1000) begin
      @(negedge clk);
      setp_n++;
    end
  endtask

  // Device clocks n edges, sampling the data line before each falling edge.
  task automatic dev_frame(input int nedges, input bit ack);
    for (int k = 1; k <= nedges; k++) begin
      repeat (10) @(negedge clk);
      frame[k-1] = ps2_data;
      if (k == 11 && ack) begin
        dev_data = 1'b0;
        repeat (3) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (10) @(negedge clk);
      dev_clk = 1'b1;
    end
    if (ack) begin
      repeat (5) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("idle_reached", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b, input logic par);
    check({tag, "_start"}, frame[0], 0);
    check({tag, "_data"}, frame[8:1], b);
    check({tag, "_parity"}, frame[9], par);
    check({tag, "_stop"}, frame[10], 1);
  endtask

  initial begin
    reset    = 1'b1;
    tx_data  = 8'h00;
    tx_start = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    frame    = '0;
    repeat (3) @(negedge clk);
    check("rst_clk_drv", ps2_clk_drive_low, 0);
    check("rst_data_drv", ps2_data_drive_low, 0);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, error}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0xF4 with ack
    d0 = done_cnt; e0 = err_cnt;
    start_and_measure(8'hF4, inh, setp);
    check("f4_inhibit", inh, INH);
    check("f4_setup", setp, SETP);
    dev_frame(11, 1'b1);
    check_frame("f4", 8'hF4, 1'b0);
    wait_idle();
    check("f4_done", done_cnt - d0, 1);
    check("f4_noerr", err_cnt - e0, 0);

    // 0xED with ack
    d0 = done_cnt; e0 = err_cnt;
    start_and_measure(8'hED, inh, setp);
    check("ed_inhibit", inh, INH);
    dev_frame(11, 1'b1);
    check_frame("ed", 8'hED, 1'b1);
    wait_idle();
    check("ed_done", done_cnt - d0, 1);

    // 0x3C, device withholds ack on edge 11
    d0 = done_cnt; e0 = err_cnt;
    start_and_measure(8'h3C, inh, setp);
    dev_frame(10, 1'b0);
    repeat (10) @(negedge clk);
    dev_clk = 1'b0;
    repeat (2) @(negedge clk);
    check("nack_err_early", error, 0);
    @(negedge clk);
    check("nack_err", error, 1);
    check("nack_drives", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
    check("nack_busy", busy, 0);
    repeat (8) @(negedge clk);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    check("nack_err_cnt", err_cnt - e0, 1);
    check("nack_nodone", done_cnt - d0, 0);

    // Device never clocks: start timeout, then 0xFF
    d0 = done_cnt; e0 = err_cnt;
    start_and_measure(8'h81, inh, setp);
    n = 0;
    while (!error && n < 2 * STO) begin
      @(negedge clk);
      n++;
    end
    check("sto_cycles", n, STO);
    check("sto_drives", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
    repeat (3) @(negedge clk);
    check("sto_err_cnt", err_cnt - e0, 1);
    d0 = done_cnt; e0 = err_cnt;
    start_and_measure(8'hFF, inh, setp);
    dev_frame(11, 1'b1);
    check_frame("ff", 8'hFF, 1'b1);
    wait_idle();
    check("ff_done", done_cnt - d0, 1);
    check("ff_noerr", err_cnt - e0, 0);

    // Reset after edge 5 of 0x00, then 0x01
    d0 = done_cnt; e0 = err_cnt;
    start_and_measure(8'h00, inh, setp);
    dev_frame(5, 1'b0);
    check("r00_bit_driven", ps2_data_drive_low, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("r00_drives", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
    check("r00_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("r00_no_pulse", {done_cnt - d0, err_cnt - e0}, 0);
    d0 = done_cnt;
    start_and_measure(8'h01, inh, setp);
    dev_frame(11, 1'b1);
    check_frame("x01", 8'h01, 1'b0);
    wait_idle();
    check("x01_done", done_cnt - d0, 1);

    // 0x55 with 0xAA requests injected while busy
    d0 = done_cnt; e0 = err_cnt;
    fork
      start_and_measure(8'h55, inh, setp);
      begin
        repeat (100) @(negedge clk);
        tx_data = 8'hAA; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    fork
      dev_frame(11, 1'b1);
      begin
        repeat (60) @(negedge clk);
        tx_data = 8'hAA; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    check_frame("x55", 8'h55, 1'b1);
    wait_idle();
    repeat (10) @(negedge clk);
    check("x55_done", done_cnt - d0, 1);
    check("x55_noerr", err_cnt - e0, 0);
    check("x55_stays_idle", busy, 0);
    check("done_err_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the host to the keyboard over the shared open-drain PS/2 clock and data lines. It is the send-side companion of the PS/2 receive decoder and sits beside it in the keyboard interface. It performs the inhibit/request-to-send sequence, shifts data out on device-generated clock edges, checks the device acknowledge and enforces protocol timeouts.

## Interface

Parameters:
- `INHIBIT_CYCLES`, 2500 — cycles the host holds clock low before requesting to send (100 us at 25 MHz).
- `SETUP_CYCLES`, 25 — cycles with both data and clock held low before clock is released.
- `START_TIMEOUT`, 375000 — maximum cycles from clock release to the first device falling edge (15 ms).
- `PACKET_TIMEOUT`, 50000 — maximum cycles from the first falling edge to the ack edge (2 ms).

Ports (clock and reset first):
- `clk`  in  1  system clock, 25 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  command byte; sampled only when `tx_start` is accepted.
- `tx_start`  in  1  one-cycle request; accepted only in IDLE.
- `ps2_clk`  in  1  PS/2 clock line as read from the pad (asynchronous).
- `ps2_data`  in  1  PS/2 data line as read from the pad (asynchronous).
- `ps2_clk_drive_low`  out  1  1 = pad pulls clock low; 0 = released (hi-Z).
- `ps2_data_drive_low`  out  1  1 = pad pulls data low; 0 = released.
- `busy`  out  1  high from the cycle after acceptance until return to IDLE.
- `done`  out  1  one-cycle pulse: byte sent and device ack seen.
- `error`  out  1  one-cycle pulse: timeout or missing ack.

## Operation

- `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer. A device falling edge is detected when the synchronized clock was 1 on the previous cycle and is 0 now.
- Latched on accept: `tx_data` into an 8-bit shift register, and the odd parity bit, equal to ~^tx_data.
- Single watchdog/delay counter, 19 bits wide, reset to 0 on every state entry. A 4-bit edge counter `bitcnt` runs from 0 to 11.

States:
- **IDLE:** all drives 0 and `busy` = 0. When `tx_start` = 1, go to INHIBIT.
- **INHIBIT:** `ps2_clk_drive_low` = 1. After INHIBIT_CYCLES cycles, go to REQUEST.
- **REQUEST:** both drives = 1, which places the start bit 0 on data. After SETUP_CYCLES cycles, go to WAIT_START.
- **WAIT_START:** clock drive = 0, data drive = 1.
  - On a falling edge: `bitcnt` = 1, data drive = ~d0, go to XFER.
  - If the counter reaches START_TIMEOUT: go to FAIL.
- **XFER:** on each falling edge, `bitcnt` increments and the next bit is driven.
  - Edges 2–8 drive d1..d7, LSB first. Edge 9 drives parity. Edge 10 releases data (stop bit = 1).
  - On edge 11, sample synchronized `ps2_data`: 0 (ack) goes to WAIT_IDLE; 1 goes to FAIL.
  - If the counter reaches PACKET_TIMEOUT before edge 11, go to FAIL.
- **WAIT_IDLE:** all drives 0.
  - When synchronized clock and data are both 1: pulse `done`, go to IDLE.
  - If the counter reaches PACKET_TIMEOUT: go to FAIL.
- **FAIL:** all drives 0, pulse `error`, go to IDLE.

Rules:
- In IDLE the block never drives either line. The receive decoder may run concurrently; the bytes the device echoes are handled there.
- `tx_start` outside IDLE is ignored and has no effect on the byte in flight.
- `done` and `error` are never asserted in the same cycle.

## Timing

- Reset values: both drives 0, `busy` 0, `done` 0, `error` 0; state IDLE; counters 0. Reset mid-transfer releases both lines immediately (asynchronously) and issues no `done`/`error` pulse.
- Accept at cycle N (`tx_start` = 1 in IDLE): `busy` and `ps2_clk_drive_low` are 1 at N+1.
- `ps2_data_drive_low` rises INHIBIT_CYCLES cycles after `ps2_clk_drive_low` rises. The clock drive falls SETUP_CYCLES later.
- Each bit is updated 3 cycles after the pad falling edge: 2 synchronizer cycles plus 1 register cycle. This is well within the ≥30 us PS/2 clock-low time.
- `done` comes 1 cycle after the synchronized lines are observed idle-high. `busy` falls in the same cycle `done`/`error` is pulsed.
- Timeout comparisons use `>=` on the 19-bit counter. The counter saturates and never wraps.

## Test plan

- Device model acks 0xF4 → 11 device clocks; observed bits 0,0,1,0,1,1,1,1, parity 0, stop 1; one `done` pulse; no `error`; `busy` low afterwards.
- Send 0xED → data bits LSB-first 1,0,1,1,0,1,1,1, parity 1; clock-low inhibit measured as exactly 2500 cycles before data drops.
- Device holds data high on the 11th edge (no ack) → `error` pulse 1 cycle after edge 11 is detected; both drives 0; no `done`.
- Device never clocks after request → `error` exactly START_TIMEOUT cycles after clock release; next `tx_start` with 0xFF completes with parity 1.
- Assert `reset` after edge 5 of a 0x00 transfer → both drives 0 in the same cycle; `busy` 0; a later 0x01 transfer sends parity 0 and completes normally.
- `tx_start` pulsed with 0xAA while busy sending 0x55 → wire carries only 0x55; exactly one `done`.
